card_dealer: RTL and testbench

Downstream controller for draw_once and owner of the deck state.
- Holds the 106-bit available_card mask that feeds draw_once.
- On request, issues draw_one handshakes and accepts each returned index.
- For each accepted index: clears the bit in available_card, sets it in hand_card, counts it.
- Two request types: deal an initial hand of HAND_SIZE cards, or draw a single card during play.

---
 rtl/card_pkg.sv | 18 +
 rtl/card_mask_update.sv | 28 ++
 rtl/card_dealer.sv | 143 ++++++++++++++
 tb/tb_card_dealer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared constants and FSM state type for the card dealer.
// Deck size, index width, hand size and watchdog limit.
package card_pkg;

  localparam int NUM_CARDS = 106;
  localparam int IDX_W     = 7;
  localparam int HAND_SIZE = 14;
  localparam int TIMEOUT   = 64;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/card_mask_update.sv
// Validates a returned card index and computes the updated masks.
// Ports: available/hand masks and idx in; idx_valid and next masks out.
module card_mask_update
  import card_pkg::*;
(
  input  logic [NUM_CARDS-1:0] available,
  input  logic [NUM_CARDS-1:0] hand,
  input  logic [IDX_W-1:0]     idx,
  output logic                 idx_valid,
  output logic [NUM_CARDS-1:0] available_nxt,
  output logic [NUM_CARDS-1:0] hand_nxt
);

  // Decoded compare per card keeps out-of-range indices harmless.
  always_comb begin
    idx_valid     = 1'b0;
    available_nxt = available;
    hand_nxt      = hand;
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (idx == IDX_W'(i)) begin
        idx_valid        = available[i];
        available_nxt[i] = 1'b0;
        hand_nxt[i]      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Deck owner: requests cards from draw_once and tracks deck/hand masks.
// Ports: clk, rst, interboard_rst, start, draw_req, dr_ready, dr_done,
// dr_idx in; draw_one, available_card, hand_card, cards_left, busy,
// deal_done, deck_empty, err out. Optional CARD_DEALER_TIMEOUT_EN
// adds a WAIT watchdog that re-requests after TIMEOUT idle cycles.
module card_dealer
  import card_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 interboard_rst,
  input  logic                 start,
  input  logic                 draw_req,
  input  logic                 dr_ready,
  input  logic                 dr_done,
  input  logic [IDX_W-1:0]     dr_idx,
  output logic                 draw_one,
  output logic [NUM_CARDS-1:0] available_card,
  output logic [NUM_CARDS-1:0] hand_card,
  output logic [IDX_W-1:0]     cards_left,
  output logic                 busy,
  output logic                 deal_done,
  output logic                 deck_empty,
  output logic                 err
);

  state_t               state, state_n;
  logic [CNT_W-1:0]     target, target_n;
  logic [CNT_W-1:0]     got, got_n;
  logic [NUM_CARDS-1:0] avail_n, hand_n;
  logic [NUM_CARDS-1:0] avail_upd, hand_upd;
  logic [IDX_W-1:0]     left_n;
  logic                 empty_n, err_n;
  logic                 idx_valid;
  logic                 any_rst;

  assign any_rst = rst | interboard_rst;

  card_mask_update u_mask (
    .available     (available_card),
    .hand          (hand_card),
    .idx           (dr_idx),
    .idx_valid     (idx_valid),
    .available_nxt (avail_upd),
    .hand_nxt      (hand_upd)
  );

`ifdef CARD_DEALER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT);
  logic [TMO_W-1:0] tmo;
  logic             expired;

  // Restarts at zero on every entry into WAIT.
  always_ff @(posedge clk) begin
    if (any_rst || state != WAIT) tmo <= '0;
    else                          tmo <= tmo + 1'b1;
  end

  assign expired = (tmo == TMO_W'(TIMEOUT - 1));
`else
  logic expired;
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (any_rst) begin
      state          <= IDLE;
      target         <= '0;
      got            <= '0;
      available_card <= '1;
      hand_card      <= '0;
      cards_left     <= IDX_W'(NUM_CARDS);
      deck_empty     <= 1'b0;
      err            <= 1'b0;
    end else begin
      state          <= state_n;
      target         <= target_n;
      got            <= got_n;
      available_card <= avail_n;
      hand_card      <= hand_n;
      cards_left     <= left_n;
      deck_empty     <= empty_n;
      err            <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    got_n    = got;
    avail_n  = available_card;
    hand_n   = hand_card;
    left_n   = cards_left;
    empty_n  = deck_empty;
    err_n    = err;
    draw_one = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          target_n = CNT_W'(HAND_SIZE);
          got_n    = '0;
          state_n  = ISSUE;
        end else if (draw_req) begin
          target_n = CNT_W'(1);
          got_n    = '0;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        if (cards_left == '0) begin
          empty_n = 1'b1;
          state_n = DONE;
        end else if (dr_ready) begin
          draw_one = 1'b1;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (dr_done) begin
          if (idx_valid) begin
            avail_n = avail_upd;
            hand_n  = hand_upd;
            left_n  = cards_left - 1'b1;
            got_n   = got + 1'b1;
            state_n = (got_n == target) ? DONE : ISSUE;
          end else begin
            err_n   = 1'b1;
            state_n = ISSUE;
          end
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = ISSUE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign deal_done = (state == DONE);

endmodule

// File: tb/tb_card_dealer.sv
// Randomized bench for card_dealer with a draw_once responder and deck model.
// Ports: none; drives and checks the card_dealer top.
module tb_card_dealer;
  import card_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, interboard_rst, start, draw_req;
  logic                 dr_ready, dr_done;
  logic [IDX_W-1:0]     dr_idx;
  logic                 draw_one, busy, deal_done, deck_empty, err;
  logic [NUM_CARDS-1:0] available_card, hand_card;
  logic [IDX_W-1:0]     cards_left;

  card_dealer dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .start          (start),
    .draw_req       (draw_req),
    .dr_ready       (dr_ready),
    .dr_done        (dr_done),
    .dr_idx         (dr_idx),
    .draw_one       (draw_one),
    .available_card (available_card),
    .hand_card      (hand_card),
    .cards_left     (cards_left),
    .busy           (busy),
    .deal_done      (deal_done),
    .deck_empty     (deck_empty),
    .err            (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit deck_m[NUM_CARDS];
  bit hand_m[NUM_CARDS];
  int left_m;
  bit err_m, empty_m;
  int plan[$];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CARDS-1:0] pack(input bit a[NUM_CARDS]);
    logic [NUM_CARDS-1:0] v;
    for (int i = 0; i < NUM_CARDS; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CARDS; i++) begin
      deck_m[i] = 1'b1;
      hand_m[i] = 1'b0;
    end
    left_m  = NUM_CARDS;
    err_m   = 1'b0;
    empty_m = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".avail"}, 128'(available_card), 128'(pack(deck_m)));
    chk({tag, ".hand"}, 128'(hand_card), 128'(pack(hand_m)));
    chk({tag, ".left"}, 128'(cards_left), 128'(left_m));
    chk({tag, ".err"}, 128'(err), 128'(err_m));
    chk({tag, ".empty"}, 128'(deck_empty), 128'(empty_m));
    chk({tag, ".busy"}, 128'(busy), 128'(0));
  endtask

  task automatic pick(output int idx);
    int cand[$];
    if (plan.size() > 0) begin
      idx = plan.pop_front();
    end else begin
      for (int i = 0; i < NUM_CARDS; i++) if (deck_m[i]) cand.push_back(i);
      idx = (cand.size() > 0) ? cand[$urandom_range(0, cand.size() - 1)] : 0;
    end
  endtask

  // One request; returns number of draw_one pulses seen.
  task automatic run_req(input bit s, input bit d, input string tag,
                         output int issues);
    int  target, got, lat, idx_out, cyc, done_cyc, last_acc;
    bit  pending, fin, unexpected;
    target = s ? HAND_SIZE : 1;
    got = 0; lat = 0; idx_out = 0; cyc = 0; issues = 0;
    done_cyc = -1; last_acc = -10;
    pending = 0; fin = 0; unexpected = 0;
    @(negedge clk);
    start = s; draw_req = d; dr_ready = 0; dr_done = 0;
    @(negedge clk);
    while (!fin && cyc < 3000) begin
      start    = ($urandom_range(0, 7) == 0);
      draw_req = ($urandom_range(0, 7) == 0);
      dr_ready = ($urandom_range(0, 3) != 0);
      dr_done  = 1'b0;
      dr_idx   = IDX_W'($urandom_range(0, NUM_CARDS - 1));
      if (pending) begin
        if (lat == 0) begin
          dr_done = 1'b1;
          dr_idx  = IDX_W'(idx_out);
          pending = 0;
          if (idx_out < NUM_CARDS && deck_m[idx_out]) begin
            deck_m[idx_out] = 1'b0;
            hand_m[idx_out] = 1'b1;
            left_m--;
            got++;
            last_acc = cyc;
          end else begin
            err_m = 1'b1;
          end
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        dr_done = 1'b1;
      end
      #1;
      if (draw_one) begin
        issues++;
        if (pending || got >= target || left_m == 0) unexpected = 1;
        pick(idx_out);
        pending = 1;
        lat = $urandom_range(0, 3);
      end
      if (deal_done) begin
        done_cyc = cyc;
        fin = 1;
      end
      cyc++;
      @(negedge clk);
    end
    start = 0; draw_req = 0; dr_done = 0; dr_ready = 0;
    chk({tag, ".finished"}, 128'(fin), 128'(1));
    chk({tag, ".no_extra_draw"}, 128'(unexpected), 128'(0));
    if (got < target) begin
      chk({tag, ".short_needs_empty"}, 128'(left_m), 128'(0));
      empty_m = 1'b1;
    end else begin
      chk({tag, ".done_lat"}, 128'(done_cyc), 128'(last_acc + 1));
    end
    chk({tag, ".done_pulse"}, 128'(deal_done), 128'(0));
    check_state(tag);
  endtask

  initial begin
    int n;
    int hc;
    rst = 1; interboard_rst = 0; start = 0; draw_req = 0;
    dr_ready = 0; dr_done = 0; dr_idx = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.draw_one", 128'(draw_one), 128'(0));
    chk("rst.deal_done", 128'(deal_done), 128'(0));
    check_state("rst");
    rst = 0;

    for (int i = 0; i < HAND_SIZE; i++) plan.push_back(i);
    run_req(1, 0, "deal0_13", n);
    chk("deal0_13.issues", 128'(n), 128'(14));
    chk("deal0_13.left", 128'(cards_left), 128'(92));
    chk("deal0_13.hand_lo", 128'(hand_card[13:0]), 128'(14'h3fff));

    plan.push_back(50);
    run_req(0, 1, "draw50", n);
    chk("draw50.issues", 128'(n), 128'(1));
    chk("draw50.bit", 128'(hand_card[50]), 128'(1));

    hc = $countones(hand_card);
    plan.push_back(120);
    run_req(0, 1, "idx120", n);
    chk("idx120.issues", 128'(n), 128'(2));
    chk("idx120.err", 128'(err), 128'(1));
    chk("idx120.hand_cnt", 128'($countones(hand_card)), 128'(hc + 1));

    @(negedge clk);
    interboard_rst = 1;
    @(negedge clk);
    interboard_rst = 0;
    model_reset();
    check_state("ibrst");
    plan.push_back(5);
    plan.push_back(5);
    run_req(1, 0, "dup5", n);
    chk("dup5.issues", 128'(n), 128'(15));
    chk("dup5.err", 128'(err), 128'(1));
    chk("dup5.hand_cnt", 128'($countones(hand_card)), 128'(14));

    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int i = 0; i < NUM_CARDS; i++) begin
      run_req(0, 1, "drain", n);
      if (n != 1) chk("drain.issues", 128'(n), 128'(1));
    end
    chk("drain.left", 128'(cards_left), 128'(0));
    chk("drain.empty_pre", 128'(deck_empty), 128'(0));
    run_req(0, 1, "empty", n);
    chk("empty.issues", 128'(n), 128'(0));
    chk("empty.flag", 128'(deck_empty), 128'(1));

    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    start = 1; dr_ready = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    #1;
    while (!draw_one && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("midrst.got_draw", 128'(draw_one), 128'(1));
    @(negedge clk);
    dr_ready = 0;
    rst = 1; dr_done = 1; dr_idx = '0;
    @(negedge clk);
    rst = 0; dr_done = 0;
    check_state("midrst");

    run_req(1, 1, "both", n);
    chk("both.issues", 128'(n), 128'(14));
    chk("both.hand_cnt", 128'($countones(hand_card)), 128'(14));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
